// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state enum, grant ids and the read byte-enable code.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DMA = 1'b1;

    localparam logic [3:0] BYTEEN_READ = 4'b0000;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one variable-latency data-memory port between the CPU MEM stage
// and a DMA/bridge requester, one outstanding access at a time.
// Ports: clk/reset; cpu_* request/response with cpu_stall; dma_* request/
// response; mem_* latched request towards memory with mem_rdata/mem_ready.
// The CPU has priority; a DMA request that has lost STARVE_LIMIT times in
// a row wins the next contested arbitration.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_byteen,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   starve_cnt;
    logic            starved;
    logic            grant;
    logic            gnt_id;

    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        gnt_id  = GNT_CPU;
        unique case (state)
            IDLE: begin
                if (cpu_req && !(dma_req && starved)) begin
                    grant   = 1'b1;
                    gnt_id  = GNT_CPU;
                    state_n = BUSY_CPU;
                end else if (dma_req) begin
                    grant   = 1'b1;
                    gnt_id  = GNT_DMA;
                    state_n = BUSY_DMA;
                end
            end
            BUSY_CPU, BUSY_DMA: begin
                if (mem_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_byteen <= BYTEEN_READ;
        end else if (grant) begin
            if (gnt_id == GNT_DMA) begin
                mem_addr   <= dma_addr;
                mem_wdata  <= dma_wdata;
                mem_byteen <= dma_byteen;
            end else begin
                mem_addr   <= cpu_addr;
                mem_wdata  <= cpu_wdata;
                mem_byteen <= cpu_byteen;
            end
        end
    end

    // Counts CPU wins over a waiting DMA request; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (gnt_id == GNT_DMA) begin
                starve_cnt <= '0;
            end else if (dma_req && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign mem_req = (state != IDLE);

    // Reset abandons an in-flight access, so no completion may leak out.
    assign cpu_done  = !reset && (state == BUSY_CPU) && mem_ready;
    assign dma_ack   = !reset && (state == BUSY_DMA) && mem_ready;
    assign cpu_rdata = cpu_done ? mem_rdata : '0;
    assign dma_rdata = dma_ack ? mem_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIM = 2;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_stall;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_byteen;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_byteen (dma_byteen),
        .dma_rdata  (dma_rdata),
        .dma_ack    (dma_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_byteen (mem_byteen),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    int          owner;
    int          owner_n;
    int          win;
    int          losses;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_byteen;
    logic        e_cdone;
    logic        e_dack;
    logic        cpu_fin;
    logic        dma_fin;

    initial begin
        clk = 0;
        reset = 1;
        cpu_req = 1;
        cpu_addr = 0;
        cpu_wdata = 0;
        cpu_byteen = 0;
        dma_req = 0;
        dma_addr = 0;
        dma_wdata = 0;
        dma_byteen = 0;
        mem_rdata = 0;
        mem_ready = 0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_byteen", mem_byteen, 0);
        chk("rst_cpu_done", cpu_done, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_starve", 32'(dut.starve_cnt), 0);
        tick();
        reset = 0;
        cpu_req = 0;

        // CPU write, zero-wait memory
        tick();
        cpu_req = 1;
        cpu_addr = 32'h0000_1004;
        cpu_wdata = 32'hDEAD_BEEF;
        cpu_byteen = 4'b1111;
        mem_ready = 1;
        @(negedge clk);
        chk("t1_c0_stall", cpu_stall, 1);
        chk("t1_c0_mem_req", mem_req, 0);
        tick();
        @(negedge clk);
        chk("t1_c1_mem_req", mem_req, 1);
        chk("t1_c1_addr", mem_addr, 32'h1004);
        chk("t1_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t1_c1_byteen", mem_byteen, 4'b1111);
        chk("t1_c1_done", cpu_done, 1);
        chk("t1_c1_stall", cpu_stall, 0);
        tick();
        cpu_req = 0;
        mem_ready = 0;
        @(negedge clk);
        chk("t1_c2_mem_req", mem_req, 0);

        // DMA read, 3-cycle memory
        tick();
        dma_req = 1;
        dma_addr = 32'h2000;
        dma_byteen = 4'b0000;
        mem_rdata = 32'hBAD0_BAD0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                mem_ready = 1;
                mem_rdata = 32'h1234_5678;
            end
            @(negedge clk);
            chk($sformatf("t2_c%0d_mem_req", c), mem_req, 1);
            chk($sformatf("t2_c%0d_ack", c), dma_ack, (c == 3));
            chk($sformatf("t2_c%0d_rdata", c), dma_rdata,
                (c == 3) ? 32'h1234_5678 : 32'h0);
            chk($sformatf("t2_c%0d_cdone", c), cpu_done, 0);
        end
        tick();
        dma_req = 0;
        mem_ready = 0;
        @(negedge clk);
        chk("t2_end_mem_req", mem_req, 0);

        // Simultaneous requests, CPU back-to-back, DMA held
        tick();
        cpu_req = 1;
        cpu_addr = 32'h100;
        dma_req = 1;
        dma_addr = 32'h200;
        mem_ready = 1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) cpu_addr = 32'h104;
            @(negedge clk);
            chk($sformatf("t3_c%0d_cdone", c), cpu_done, (c == 1 || c == 3));
            chk($sformatf("t3_c%0d_dack", c), dma_ack, (c == 5));
            chk($sformatf("t3_c%0d_mem_req", c), mem_req, (c % 2));
            if (c == 1) chk("t3_addr1", mem_addr, 32'h100);
            if (c == 2) chk("t3_starve1", 32'(dut.starve_cnt), 1);
            if (c == 3) chk("t3_addr3", mem_addr, 32'h104);
            if (c == 4) chk("t3_starve2", 32'(dut.starve_cnt), 2);
            if (c == 5) begin
                chk("t3_addr5", mem_addr, 32'h200);
                chk("t3_starve0", 32'(dut.starve_cnt), 0);
            end
        end
        tick();
        cpu_req = 0;
        dma_req = 0;
        mem_ready = 0;

        // Reset in cycle 2 of a 5-cycle CPU access
        tick();
        cpu_req = 1;
        cpu_addr = 32'h3000;
        cpu_wdata = 32'h5555_AAAA;
        cpu_byteen = 4'b0011;
        tick();
        @(negedge clk);
        chk("t4_c1_mem_req", mem_req, 1);
        tick();
        reset = 1;
        mem_ready = 1;
        @(negedge clk);
        chk("t4_c2_done", cpu_done, 0);
        chk("t4_c2_stall", cpu_stall, 1);
        tick();
        reset = 0;
        cpu_req = 0;
        mem_ready = 0;
        @(negedge clk);
        chk("t4_c3_mem_req", mem_req, 0);
        chk("t4_c3_done", cpu_done, 0);
        chk("t4_c3_state", 32'(dut.state), 32'(IDLE));
        chk("t4_c3_addr", mem_addr, 0);
        chk("t4_c3_wdata", mem_wdata, 0);
        chk("t4_c3_byteen", mem_byteen, 0);

        // DMA request dropped during BUSY
        tick();
        dma_req = 1;
        dma_addr = 32'h4000;
        dma_wdata = 32'hCAFE_0000;
        dma_byteen = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 2) dma_req = 0;
            if (c == 4) begin
                mem_ready = 1;
                mem_rdata = 32'h0BAD_F00D;
            end
            @(negedge clk);
            chk($sformatf("t5_c%0d_mem_req", c), mem_req, 1);
            chk($sformatf("t5_c%0d_ack", c), dma_ack, (c == 4));
        end
        chk("t5_rdata", dma_rdata, 32'h0BAD_F00D);
        tick();
        mem_ready = 0;
        @(negedge clk);
        chk("t5_end_mem_req", mem_req, 0);
        chk("t5_end_state", 32'(dut.state), 32'(IDLE));
        chk("t5_end_ack", dma_ack, 0);

        // Randomized traffic against the reference model
        owner = 0;
        losses = 0;
        cpu_fin = 0;
        dma_fin = 0;
        e_addr = 0;
        e_wdata = 0;
        e_byteen = 0;
        for (int n = 0; n < 600; n++) begin
            tick();
            if (cpu_fin) begin
                cpu_req = 0;
                cpu_fin = 0;
            end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1;
                cpu_addr = $urandom & 32'hFFFF_FFFC;
                cpu_wdata = $urandom;
                cpu_byteen = 4'($urandom_range(0, 15));
            end
            if (dma_fin) begin
                dma_req = 0;
                dma_fin = 0;
            end else if (!dma_req && $urandom_range(0, 1) == 0) begin
                dma_req = 1;
                dma_addr = $urandom & 32'hFFFF_FFFC;
                dma_wdata = $urandom;
                dma_byteen = 4'($urandom_range(0, 15));
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            @(negedge clk);
            owner_n = owner;
            e_cdone = (owner == 1) && mem_ready;
            e_dack = (owner == 2) && mem_ready;
            chk("r_mem_req", mem_req, (owner != 0));
            chk("r_cdone", cpu_done, e_cdone);
            chk("r_dack", dma_ack, e_dack);
            chk("r_crdata", cpu_rdata, e_cdone ? mem_rdata : 32'h0);
            chk("r_drdata", dma_rdata, e_dack ? mem_rdata : 32'h0);
            chk("r_stall", cpu_stall, cpu_req && !e_cdone);
            if (owner == 0) begin
                win = 0;
                if (cpu_req && dma_req) win = (losses >= LIM) ? 2 : 1;
                else if (cpu_req) win = 1;
                else if (dma_req) win = 2;
                if (win == 2) losses = 0;
                else if (win == 1 && dma_req && losses < LIM) losses++;
                if (win == 1) begin
                    e_addr = cpu_addr;
                    e_wdata = cpu_wdata;
                    e_byteen = cpu_byteen;
                end else if (win == 2) begin
                    e_addr = dma_addr;
                    e_wdata = dma_wdata;
                    e_byteen = dma_byteen;
                end
                owner_n = win;
            end else begin
                chk("r_mem_addr", mem_addr, e_addr);
                chk("r_mem_wdata", mem_wdata, e_wdata);
                chk("r_mem_byteen", mem_byteen, e_byteen);
                if (mem_ready) begin
                    if (owner == 1) cpu_fin = 1;
                    else dma_fin = 1;
                    owner_n = 0;
                end
            end
            owner = owner_n;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
